// File: rtl/n1_ir_stage.sv
// n1_ir_stage: N1 instruction register stage with one-entry stash, forced opcodes and opcode decode
// Inputs : clk_i, async_rst_i, pbus_dat_i[15:0] program bus data,
//          fc2ir_* strobes from flow control (capture, stash, expend, force_*).
// Outputs: ir2fc_* control flags, ir2dsp_adr_o target field, ir2prs_lit_o/lit_val_o literal,
//          ir2alu_opc_o ALU field, prb_* register probes.
module n1_ir_stage #(
    parameter logic [12:0] IRQ_ADR  = 13'h0010,
    parameter logic [15:0] DROP_OPC = 16'h0400
) (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic [15:0] pbus_dat_i,
    input  logic        fc2ir_capture_i,
    input  logic        fc2ir_stash_i,
    input  logic        fc2ir_expend_i,
    input  logic        fc2ir_force_eow_i,
    input  logic        fc2ir_force_0call_i,
    input  logic        fc2ir_force_call_i,
    input  logic        fc2ir_force_drop_i,
    input  logic        fc2ir_force_nop_i,
    output logic        ir2fc_eow_o,
    output logic        ir2fc_eow_postpone_o,
    output logic        ir2fc_jump_or_call_o,
    output logic        ir2fc_bra_o,
    output logic        ir2fc_scyc_o,
    output logic        ir2fc_mem_o,
    output logic        ir2fc_mem_rd_o,
    output logic        ir2fc_madr_sel_o,
    output logic [12:0] ir2dsp_adr_o,
    output logic        ir2prs_lit_o,
    output logic [12:0] ir2prs_lit_val_o,
    output logic [9:0]  ir2alu_opc_o,
    output logic [15:0] prb_ir_o,
    output logic [15:0] prb_ir_stash_o,
    output logic        prb_ir_stash_vld_o
);
    logic [15:0] ir_q, ir_d, ir_sel, stash_q, stash_d;
    logic        stash_vld_q, stash_vld_d;

    always_comb begin
        ir_sel = fc2ir_force_0call_i ? 16'h6000 :
                 fc2ir_force_call_i  ? {3'b011, IRQ_ADR} :
                 fc2ir_force_drop_i  ? DROP_OPC :
                 fc2ir_force_nop_i   ? 16'h0000 :
                 fc2ir_expend_i      ? stash_q :
                 fc2ir_capture_i     ? pbus_dat_i : ir_q;
        ir_d    = ir_sel | {fc2ir_force_eow_i, 15'h0000};
        stash_d = fc2ir_stash_i ? pbus_dat_i : stash_q;
        // A forced call flushes the prefetch; a fresh stash outranks a simultaneous expend.
        stash_vld_d = (fc2ir_force_0call_i | fc2ir_force_call_i) ? 1'b0 :
                      fc2ir_stash_i  ? 1'b1 :
                      fc2ir_expend_i ? 1'b0 : stash_vld_q;
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            ir_q        <= 16'h0000;
            stash_q     <= 16'h0000;
            stash_vld_q <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            stash_q     <= stash_d;
            stash_vld_q <= stash_vld_d;
        end
    end

    always_comb begin
        ir2fc_jump_or_call_o = ir_q[14:13] == 2'b11;
        ir2fc_bra_o          = ir_q[14:13] == 2'b10;
        ir2prs_lit_o         = ir_q[14:13] == 2'b01;
        ir2fc_mem_o          = (ir_q[14:13] == 2'b00) & ir_q[12];
        ir2fc_mem_rd_o       = ir2fc_mem_o & ir_q[11];
        ir2fc_madr_sel_o     = ir2fc_mem_o & ir_q[10];
        ir2fc_scyc_o         = ~ir2fc_jump_or_call_o & ~ir2fc_bra_o & ~ir2fc_mem_o;
        ir2fc_eow_o          = ir_q[15];
        ir2fc_eow_postpone_o = ir_q[15] & (ir2fc_bra_o | ir2fc_mem_o);
        ir2dsp_adr_o         = ir_q[12:0];
        ir2prs_lit_val_o     = ir_q[12:0];
        ir2alu_opc_o         = ir_q[9:0];
    end

    assign prb_ir_o           = ir_q;
    assign prb_ir_stash_o     = stash_q;
    assign prb_ir_stash_vld_o = stash_vld_q;
endmodule

// File: tb/tb_n1_ir_stage.sv
// tb_n1_ir_stage: directed scoreboard bench for n1_ir_stage
module tb_n1_ir_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] pbus = 16'h0000;
    logic        cap = 0, stsh = 0, exp_s = 0, feow = 0, f0c = 0, fc = 0, fd = 0, fn = 0;
    logic        eow, pp, jc, bra, scyc, mem, rd, madr, lit;
    logic [12:0] adr, lval;
    logic [9:0]  alu;
    logic [15:0] p_ir, p_st;
    logic        p_vld;

    n1_ir_stage dut (
        .clk_i(clk), .async_rst_i(rst), .pbus_dat_i(pbus),
        .fc2ir_capture_i(cap), .fc2ir_stash_i(stsh), .fc2ir_expend_i(exp_s),
        .fc2ir_force_eow_i(feow), .fc2ir_force_0call_i(f0c), .fc2ir_force_call_i(fc),
        .fc2ir_force_drop_i(fd), .fc2ir_force_nop_i(fn),
        .ir2fc_eow_o(eow), .ir2fc_eow_postpone_o(pp), .ir2fc_jump_or_call_o(jc),
        .ir2fc_bra_o(bra), .ir2fc_scyc_o(scyc), .ir2fc_mem_o(mem), .ir2fc_mem_rd_o(rd),
        .ir2fc_madr_sel_o(madr), .ir2dsp_adr_o(adr), .ir2prs_lit_o(lit),
        .ir2prs_lit_val_o(lval), .ir2alu_opc_o(alu),
        .prb_ir_o(p_ir), .prb_ir_stash_o(p_st), .prb_ir_stash_vld_o(p_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] ir, st;
        logic        vld;
        logic [8:0]  fl;
        logic [12:0] adr;
        logic [9:0]  alu;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0;
    logic [8:0] fl_now;

    always @(posedge clk) cyc <= cyc + 1;

    assign fl_now = {eow, pp, jc, bra, scyc, mem, rd, madr, lit};

    // Monitor: each expected entry becomes due one edge after its stimulus.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (p_ir !== e.ir || p_st !== e.st || p_vld !== e.vld || fl_now !== e.fl ||
                adr !== e.adr || lval !== e.adr || alu !== e.alu) begin
                n_bad++;
                $display("FAIL %s: got ir=%h st=%h vld=%b fl=%b adr=%h lv=%h alu=%h want ir=%h st=%h vld=%b fl=%b adr=%h alu=%h",
                         e.name, p_ir, p_st, p_vld, fl_now, adr, lval, alu,
                         e.ir, e.st, e.vld, e.fl, e.adr, e.alu);
            end
        end
    end

    // Strobe order: {capture, stash, expend, force_eow, force_0call, force_call, force_drop, force_nop}
    // Flag order:   {eow, postpone, jump_or_call, bra, scyc, mem, mem_rd, madr_sel, lit}
    task automatic step(input string nm, input logic [7:0] s, input logic [15:0] d,
                        input logic [15:0] e_ir, input logic [15:0] e_st, input logic e_vld,
                        input logic [8:0] e_fl, input logic [12:0] e_adr, input logic [9:0] e_alu);
        exp_t e;
        @(posedge clk);
        #1;
        {cap, stsh, exp_s, feow, f0c, fc, fd, fn} = s;
        pbus = d;
        e.name = nm; e.ir = e_ir; e.st = e_st; e.vld = e_vld; e.fl = e_fl;
        e.adr = e_adr; e.alu = e_alu; e.due = cyc + 1;
        q.push_back(e);
    endtask

    task automatic direct(input string nm, input logic [17:0] got, input logic [17:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic drain();
        int t = 0;
        @(posedge clk);
        #1;
        {cap, stsh, exp_s, feow, f0c, fc, fd, fn} = 8'h00;
        while (q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #23 rst = 1'b0;
        #1 direct("reset", {p_ir, scyc, p_vld}, {16'h0000, 1'b1, 1'b0});
        step("cap_E005",    8'b1000_0000, 16'hE005, 16'hE005, 16'h0000, 0, 9'b101000000, 13'h0005, 10'h005);
        step("stash_3234",  8'b0100_0000, 16'h3234, 16'hE005, 16'h3234, 1, 9'b101000000, 13'h0005, 10'h005);
        step("expend_lit",  8'b0010_0000, 16'hFFFF, 16'h3234, 16'h3234, 0, 9'b000010001, 13'h1234, 10'h234);
        step("stash_1111",  8'b0100_0000, 16'h1111, 16'h3234, 16'h1111, 1, 9'b000010001, 13'h1234, 10'h234);
        step("exp_and_st",  8'b0110_0000, 16'h2222, 16'h1111, 16'h2222, 1, 9'b000001000, 13'h1111, 10'h111);
        step("call_flush",  8'b1000_0100, 16'hABCD, 16'h6010, 16'h2222, 0, 9'b001000000, 13'h0010, 10'h010);
        step("0call_nop",   8'b0000_1001, 16'hABCD, 16'h6000, 16'h2222, 0, 9'b001000000, 13'h0000, 10'h000);
        step("cap_eow_bra", 8'b1000_0000, 16'hC000, 16'hC000, 16'h2222, 0, 9'b110100000, 13'h0000, 10'h000);
        step("cap_1000",    8'b1000_0000, 16'h1000, 16'h1000, 16'h2222, 0, 9'b000001000, 13'h1000, 10'h000);
        step("force_eow",   8'b0001_0000, 16'h0000, 16'h9000, 16'h2222, 0, 9'b110001000, 13'h1000, 10'h000);
        step("drop_vs_cap", 8'b1000_0010, 16'hE005, 16'h0400, 16'h2222, 0, 9'b000010000, 13'h0400, 10'h000);
        step("cap_eow_mem", 8'b1001_0000, 16'h1C03, 16'h9C03, 16'h2222, 0, 9'b110001110, 13'h1C03, 10'h003);
        step("stash_0055",  8'b0100_0000, 16'h0055, 16'h9C03, 16'h0055, 1, 9'b110001110, 13'h1C03, 10'h003);
        step("expend_55",   8'b0010_0000, 16'h0000, 16'h0055, 16'h0055, 0, 9'b000010000, 13'h0055, 10'h055);
        step("expend_inv",  8'b0010_0000, 16'h0000, 16'h0055, 16'h0055, 0, 9'b000010000, 13'h0055, 10'h055);
        step("nop_vs_exp",  8'b0010_0001, 16'h0000, 16'h0000, 16'h0055, 0, 9'b000010000, 13'h0000, 10'h000);
        step("stash_again", 8'b0100_0000, 16'h7777, 16'h0000, 16'h7777, 1, 9'b000010000, 13'h0000, 10'h000);
        step("cap_E005_b",  8'b1000_0000, 16'hE005, 16'hE005, 16'h7777, 1, 9'b101000000, 13'h0005, 10'h005);
        drain();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 direct("async_rst", {p_ir, scyc, p_vld}, {16'h0000, 1'b1, 1'b0});
        direct("async_rst_st", {p_st, jc, eow}, {16'h0000, 1'b0, 1'b0});
        #10 rst = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
